iq_channel_grabber: RTL

- Parametrised successor to the two-channel IQ deserializer that sits behind the `dsp` down-converter/CIC.
- Takes the time-multiplexed result stream (I0,Q0,I1,Q1,…) and its per-word strobe, and latches N_CH I/Q pairs into parallel registers.
- Optionally averages 2^avg_log2 consecutive frames before presenting them.
- Detects truncated frames; counts delivered frames for the CSR/plotting path.

---
 rtl/iq_channel_grabber.sv | 126 ++++++++++++
 1 files changed

// File: rtl/iq_channel_grabber.sv
// iq_channel_grabber: deserialises a time-multiplexed I/Q word stream
// (I0,Q0,I1,Q1,...) into N_CH parallel I/Q pairs, optionally averaging
// 2^A consecutive frames. It flags truncated frames and counts delivered
// output samples.
//
// Handshake: strobe_in qualifies stream_in on every cycle it is high.
// There is no back-pressure. strobe_out is a one-cycle pulse, and iq_out is
// valid from that cycle until the next pulse.
`timescale 1ns/1ps
module iq_channel_grabber #(
  parameter int DW           = 20,
  parameter int N_CH         = 4,
  parameter int AVG_MAX_LOG2 = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic signed [DW-1:0]   stream_in,
  input  logic                   strobe_in,
  input  logic [3:0]             avg_log2,
  input  logic                   clr_err,
  output logic                   strobe_out,
  output logic [2*N_CH*DW-1:0]   iq_out,
  output logic [15:0]            frame_cnt,
  output logic                   err_trunc
);

  localparam int NW = 2 * N_CH;                          // words per frame
  localparam int AW = DW + AVG_MAX_LOG2;                 // accumulator width
  localparam int WI = (NW > 1) ? $clog2(NW) : 1;         // word index width
  localparam int FW = (AVG_MAX_LOG2 > 0) ? AVG_MAX_LOG2 : 1; // frame-in-block width

  logic [WI-1:0]         w_q, w_d;          // word index within frame
  logic [FW-1:0]         fcnt_q, fcnt_d;    // frame index within averaging block
  logic [3:0]            a_q, a_d;          // averaging exponent of current block
  logic signed [AW-1:0]  acc_q [NW];
  logic signed [AW-1:0]  acc_d [NW];
  logic                  strobe_q, strobe_d;
  logic [2*N_CH*DW-1:0]  iq_q, iq_d;
  logic [15:0]           frame_cnt_q, frame_cnt_d;
  logic                  err_q, err_d;

  logic [3:0]            a_clamp;
  logic signed [AW-1:0]  word_ext;
  logic signed [AW-1:0]  acc_new;
  logic                  first_frame;
  logic                  last_word;
  logic                  block_last;
  logic                  trunc;

  // Next-state logic: word/frame sequencing, accumulation, output capture, error flag
  always_comb begin
    w_d         = w_q;
    fcnt_d      = fcnt_q;
    a_d         = a_q;
    strobe_d    = 1'b0;
    iq_d        = iq_q;
    frame_cnt_d = frame_cnt_q;
    err_d       = err_q;
    for (int k = 0; k < NW; k++) acc_d[k] = acc_q[k];

    a_clamp     = (int'(avg_log2) > AVG_MAX_LOG2) ? 4'(AVG_MAX_LOG2) : avg_log2;
    word_ext    = AW'(stream_in);
    first_frame = (fcnt_q == '0);
    last_word   = (w_q == WI'(NW - 1));
    // The exponent is already latched by the time the last word of any frame arrives.
    block_last  = (fcnt_q == FW'((1 << a_q) - 1));
    trunc       = !strobe_in && (w_q != '0);
    // The first frame of a block loads, so there is no separate clear pass.
    acc_new     = first_frame ? word_ext : acc_q[w_q] + word_ext;

    if (strobe_in) begin
      if (first_frame && (w_q == '0)) a_d = a_clamp;
      acc_d[w_q] = acc_new;
      if (last_word) begin
        w_d = '0;
        if (block_last) begin
          fcnt_d      = '0;
          strobe_d    = 1'b1;
          frame_cnt_d = frame_cnt_q + 16'd1;
          // acc_d includes the final word that is being added this cycle.
          for (int k = 0; k < NW; k++) iq_d[k*DW +: DW] = DW'(acc_d[k] >>> a_q);
        end else begin
          fcnt_d = fcnt_q + FW'(1);
        end
      end else begin
        w_d = w_q + WI'(1);
      end
    end else if (trunc) begin
      // Drop the partial frame and the rest of the averaging block.
      w_d    = '0;
      fcnt_d = '0;
    end

    if (clr_err)    err_d = 1'b0;
    else if (trunc) err_d = 1'b1;
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_q         <= '0;
      fcnt_q      <= '0;
      a_q         <= '0;
      strobe_q    <= 1'b0;
      iq_q        <= '0;
      frame_cnt_q <= '0;
      err_q       <= 1'b0;
      for (int k = 0; k < NW; k++) acc_q[k] <= '0;
    end else begin
      w_q         <= w_d;
      fcnt_q      <= fcnt_d;
      a_q         <= a_d;
      strobe_q    <= strobe_d;
      iq_q        <= iq_d;
      frame_cnt_q <= frame_cnt_d;
      err_q       <= err_d;
      for (int k = 0; k < NW; k++) acc_q[k] <= acc_d[k];
    end
  end

  assign strobe_out = strobe_q;
  assign iq_out     = iq_q;
  assign frame_cnt  = frame_cnt_q;
  assign err_trunc  = err_q;

endmodule
